// File: rtl/change_dispenser.sv
// Coin-hopper payout engine: pays an amount greedily, largest coin first,
// one valid/ready handshake per coin, with per-denomination inventory.

module change_dispenser_lane #(
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             refill,
  input  logic [CNT_W-1:0] refill_cnt,
  input  logic             take,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   sum;

  // Saturating refill first, then the dispense decrement, floored at zero.
  always_comb begin
    sum     = {1'b0, count_q} + (refill ? {1'b0, refill_cnt} : '0);
    count_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    if (take && count_d != '0) count_d = count_d - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= CNT_W'(INIT_COUNT);
    else          count_q <= count_d;

  assign count = count_q;
endmodule

module change_dispenser #(
  parameter int kNumCoins  = 3,
  parameter int COIN_VAL0  = 100,
  parameter int COIN_VAL1  = 500,
  parameter int COIN_VAL2  = 1000,
  parameter int CNT_W      = 8,
  parameter int INIT_COUNT = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [31:0]          i_amount,
  input  logic                 i_coin_ready,
  input  logic                 i_refill,
  input  logic [kNumCoins-1:0] i_refill_sel,
  input  logic [CNT_W-1:0]     i_refill_cnt,
  output logic                 o_coin_valid,
  output logic [kNumCoins-1:0] o_coin,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_short,
  output logic [31:0]          o_remaining,
  output logic [kNumCoins-1:0] o_empty
);
  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_e;

  localparam logic [2:0][31:0] VALS = {32'(COIN_VAL2), 32'(COIN_VAL1), 32'(COIN_VAL0)};

  state_e                           state_q, state_d;
  logic [31:0]                      rem_q, rem_d;
  logic [kNumCoins-1:0]             coin_q, coin_d;
  logic [31:0]                      remaining_q, remaining_d;
  logic                             short_q, short_d;
  logic [kNumCoins-1:0][CNT_W-1:0]  count;
  logic [kNumCoins-1:0]             take, pick;
  logic                             found, hs, refill_ok;
  logic [31:0]                      coin_val;

  assign refill_ok = i_refill && (i_refill_sel != '0) &&
                     ((i_refill_sel & (i_refill_sel - 1'b1)) == '0);
  assign hs        = (state_q == DISPENSE) && i_coin_ready;
  assign take      = hs ? coin_q : '0;

  for (genvar g = 0; g < kNumCoins; g++) begin : g_lane
    change_dispenser_lane #(.CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT)) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .refill     (refill_ok && i_refill_sel[g]),
      .refill_cnt (i_refill_cnt),
      .take       (take[g]),
      .count      (count[g])
    );
    assign o_empty[g] = (count[g] == '0);
  end

  // Later (higher) indices override, so the largest payable coin wins.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    coin_val = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (VALS[i] <= rem_q && count[i] != '0) begin
        pick    = '0;
        pick[i] = 1'b1;
        found   = 1'b1;
      end
      if (coin_q[i]) coin_val = VALS[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    coin_d      = coin_q;
    remaining_d = remaining_q;
    short_d     = short_q;
    case (state_q)
      IDLE: if (i_start) begin
        rem_d   = i_amount;
        short_d = 1'b0;
        state_d = SELECT;
      end
      SELECT: if (found) begin
        coin_d  = pick;
        state_d = DISPENSE;
      end else begin
        remaining_d = rem_q;
        short_d     = (rem_q != '0);
        state_d     = DONE;
      end
      DISPENSE: if (i_coin_ready) begin
        rem_d   = rem_q - coin_val;
        state_d = SELECT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      coin_q      <= '0;
      remaining_q <= '0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      coin_q      <= coin_d;
      remaining_q <= remaining_d;
      short_q     <= short_d;
    end

  assign o_coin_valid = (state_q == DISPENSE);
  assign o_coin       = o_coin_valid ? coin_q : '0;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);
  assign o_short      = short_q;
  assign o_remaining  = remaining_q;
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Physical change-payout engine for the vending machine.
- Accepts a return amount, in the same units as the coin values, from the balance/return logic.
- Pays the amount out one coin at a time to a coin hopper over a valid/ready handshake, largest denomination first.
- Tracks per-denomination hopper inventory and reports any amount it cannot pay.

Parameters:
- kNumCoins, 3, number of denominations (index 0 = smallest).
- COIN_VAL0, 100, value of coin 0.
- COIN_VAL1, 500, value of coin 1.
- COIN_VAL2, 1000, value of coin 2.
- CNT_W, 8, inventory counter width per denomination.
- INIT_COUNT, 10, inventory of each denomination after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle request to pay i_amount; sampled only in IDLE.
- i_amount  input  32  unsigned amount to pay, sampled with i_start.
- i_coin_ready  input  1  hopper accepts the presented coin this cycle.
- i_refill  input  1  refill strobe.
- i_refill_sel  input  kNumCoins  one-hot denomination to refill.
- i_refill_cnt  input  CNT_W  number of coins added.
- o_coin_valid  output  1  a coin is presented to the hopper.
- o_coin  output  kNumCoins  one-hot denomination presented; 0 when not valid.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when a payout finishes.
- o_short  output  1  valid with o_done; 1 if o_remaining != 0.
- o_remaining  output  32  unpaid amount; holds its value until the next i_start.
- o_empty  output  kNumCoins  bit i = inventory of coin i is 0.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - o_coin_valid, o_coin, o_busy, o_done, o_short are 0; o_remaining is 0.
  - All inventory counters are set to INIT_COUNT; o_empty is 0.
  - Reset mid-payout abandons the payout immediately; no o_done.
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE:
  - On i_start, latch i_amount into rem, clear o_short, go to SELECT.
  - i_start in any other state is ignored.
- SELECT (1 cycle):
  - Choose the highest index i with COIN_VALi <= rem and count[i] > 0.
  - If found, register o_coin = one-hot(i) and go to DISPENSE.
  - If none, go to DONE.
- DISPENSE:
  - o_coin_valid = 1; o_coin is held stable until the handshake.
  - Handshake completes on a clock edge where i_coin_ready = 1.
  - On handshake: rem -= COIN_VALi, count[i] -= 1, drop o_coin_valid, go to SELECT.
  - i_coin_ready while o_coin_valid = 0 has no effect.
- DONE (1 cycle):
  - o_done = 1, o_remaining = rem, o_short = (rem != 0), then go to IDLE.
  - rem = 0 and a non-multiple-of-100 residue both end here; the residue stays in o_remaining.
- Latency:
  - i_start at edge t gives first o_coin_valid at t+2.
  - Maximum throughput is one coin per 2 cycles with ready tied high.
  - i_amount = 0 gives o_done at t+2 with no coin.
- Refill:
  - Legal in any state: count[sel] += i_refill_cnt, saturating at 2^CNT_W - 1.
  - i_refill_sel other than one-hot is ignored.
  - Refill and dispense on the same denomination in the same cycle: count = sat(count + cnt) - 1, never below 0.
  - A refill during DISPENSE does not change the coin already presented.
- o_empty is combinational from the counters.
- Arithmetic: rem is 32-bit unsigned and never underflows, guaranteed by the SELECT rule.

Test Plan:
- Reset, i_start with i_amount = 1600, ready = 1 -> coins 1000, 500, 100 on o_coin (100, 010, 001); o_done with o_short = 0 and o_remaining = 0; counts end at 9, 9, 9.
- Inventory: reset with INIT_COUNT = 1, pay 2000 -> coins 1000, 500, 100; o_done with o_short = 1 and o_remaining = 400; o_empty = 111.
- Backpressure: pay 500 with ready low for 5 cycles -> o_coin_valid and o_coin = 010 stable throughout; exactly one handshake; o_done 2 cycles after ready rises.
- Edge amounts: i_amount = 0 -> o_done at t+2, no coin. i_amount = 150 -> one 100 coin, then o_remaining = 50, o_short = 1.
- Ignored start and saturation: i_start during DISPENSE is ignored. Refill 250 coins onto a count of 10 -> saturates at 255. Simultaneous refill (cnt 3) and 100-coin dispense at count 0 gives a count of 2.
- Async reset asserted mid-DISPENSE -> o_coin_valid drops without waiting for a clock edge; no o_done; counters return to INIT_COUNT.
